// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, forwards from EX/WB and
// detects load-use hazards, then registers one operand bundle per transfer.
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rm,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_mem_read,
  input  logic [63:0] in_imm,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [63:0] rf_rdata1,
  input  logic [63:0] rf_rdata2,
  input  logic        ex_we,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_addr,
  input  logic [63:0] ex_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [63:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_a,
  output logic [63:0] out_b,
  output logic [63:0] out_imm,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic [15:0] stall_cnt
);

  localparam logic [4:0] ZeroReg = 5'd31;

  logic        out_valid_q, out_valid_d;
  logic [63:0] out_a_q, out_a_d;
  logic [63:0] out_b_q, out_b_d;
  logic [63:0] out_imm_q, out_imm_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_reg_write_q, out_reg_write_d;
  logic        out_mem_read_q, out_mem_read_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        hazard;
  logic        accept;
  logic [63:0] op_a;
  logic [63:0] op_b;

  // EX wins over WB; a load in EX has no data yet and is never a forward source.
  function automatic logic [63:0] resolve(
    input logic [4:0]  addr,
    input logic [63:0] rf_data,
    input logic        f_ex_we,
    input logic        f_ex_is_load,
    input logic [4:0]  f_ex_addr,
    input logic [63:0] f_ex_data,
    input logic        f_wb_we,
    input logic [4:0]  f_wb_addr,
    input logic [63:0] f_wb_data
  );
    logic [63:0] res;
    if (addr == ZeroReg) begin
      res = 64'h0;
    end else if (f_ex_we && !f_ex_is_load && (f_ex_addr == addr)) begin
      res = f_ex_data;
    end else if (f_wb_we && (f_wb_addr == addr)) begin
      res = f_wb_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  assign rf_raddr1 = in_rn;
  assign rf_raddr2 = in_rm;

  always_comb begin
    op_a = resolve(in_rn, rf_rdata1, ex_we, ex_is_load, ex_addr, ex_data,
                   wb_we, wb_addr, wb_data);
    op_b = resolve(in_rm, rf_rdata2, ex_we, ex_is_load, ex_addr, ex_data,
                   wb_we, wb_addr, wb_data);
  end

  assign hazard = in_valid && ex_we && ex_is_load && (ex_addr != ZeroReg) &&
                  ((ex_addr == in_rn) || (ex_addr == in_rm));

  assign in_ready = rst && (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_a_d         = out_a_q;
    out_b_d         = out_b_q;
    out_imm_d       = out_imm_q;
    out_rd_d        = out_rd_q;
    out_reg_write_d = out_reg_write_q;
    out_mem_read_d  = out_mem_read_q;
    out_valid_d     = out_valid_q && !out_ready;
    stall_cnt_d     = stall_cnt_q;

    if (accept) begin
      out_valid_d     = 1'b1;
      out_a_d         = op_a;
      out_b_d         = op_b;
      out_imm_d       = in_imm;
      out_rd_d        = in_rd;
      out_reg_write_d = in_reg_write;
      out_mem_read_d  = in_mem_read;
    end

    if (hazard && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q     <= 1'b0;
      out_a_q         <= 64'h0;
      out_b_q         <= 64'h0;
      out_imm_q       <= 64'h0;
      out_rd_q        <= 5'd0;
      out_reg_write_q <= 1'b0;
      out_mem_read_q  <= 1'b0;
      stall_cnt_q     <= 16'd0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_a_q         <= out_a_d;
      out_b_q         <= out_b_d;
      out_imm_q       <= out_imm_d;
      out_rd_q        <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
      out_mem_read_q  <= out_mem_read_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_a         = out_a_q;
  assign out_b         = out_b_q;
  assign out_imm       = out_imm_q;
  assign out_rd        = out_rd_q;
  assign out_reg_write = out_reg_write_q;
  assign out_mem_read  = out_mem_read_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  input  1  synchronous, active-low reset.
REQ-003 SHALL: in_valid  input  1  decoded instruction present.
REQ-004 SHALL: in_ready  output  1  stage accepts the instruction this cycle.
REQ-005 SHALL: in_rn, in_rm, in_rd  input  5 each  source A, source B, destination register.
REQ-006 SHALL: in_reg_write, in_mem_read  input  1 each  instruction writes rd / instruction is a load.
REQ-007 SHALL: in_imm  input  64  sign-extended immediate, passed through unchanged.
REQ-008 SHALL: rf_raddr1, rf_raddr2  output  5 each  register-file read addresses.
REQ-009 SHALL: rf_rdata1, rf_rdata2  input  64 each  combinational register-file read data.
REQ-010 SHALL: ex_we, ex_is_load  input  1 each  EX stage will write / EX result is a load.
REQ-011 SHALL: ex_addr  input  5  EX destination; ex_data  input  64  EX result.
REQ-012 SHALL: wb_we  input  1  writeback enable, identical to the register-file write port.
REQ-013 SHALL: wb_addr  input  5  writeback register; wb_data  input  64  writeback data.
REQ-014 SHALL: out_valid  output  1  operand bundle valid; out_ready  input  1  downstream accepts.
REQ-015 SHALL: out_a, out_b, out_imm  output  64 each  resolved operands and immediate.
REQ-016 SHALL: out_rd  output  5; out_reg_write, out_mem_read  output  1 each  registered control.
REQ-017 SHALL: stall_cnt  output  16  count of load-use stall cycles, saturating.

Function
REQ-018 SHALL: rf_raddr1 = in_rn and rf_raddr2 = in_rm combinationally, every cycle.
REQ-019 SHALL: resolve each operand with priority (1) address 31 -> 64'h0, (2) ex_we && !ex_is_load && ex_addr match -> ex_data, (3) wb_we && wb_addr match -> wb_data, (4) rf_rdata.
REQ-020 SHALL: never forward to or from register 31, even when ex_we/wb_we target address 31.
REQ-021 SHALL: hazard = in_valid && ex_we && ex_is_load && ex_addr != 31 && (ex_addr == in_rn || ex_addr == in_rm).
REQ-022 SHALL: in_ready = (!out_valid || out_ready) && !hazard.
REQ-023 SHALL: on in_valid && in_ready, register the resolved out_a/out_b and all control/imm, and set out_valid=1 on the next cycle (latency 1).
REQ-024 SHALL: when out_valid && !out_ready, hold every output stable (no change of any bit).
REQ-025 SHALL: when out_ready (or !out_valid) and no transfer is accepted, set out_valid=0 on the next cycle (bubble); data outputs may hold their stale values.
REQ-026 SHALL: full throughput, one transfer per cycle, when out_ready=1 and hazard=0.
REQ-027 SHALL: increment stall_cnt by 1 in each cycle where hazard=1, saturating at 16'hFFFF.
REQ-028 SHALL: when EX and WB hit the same address in the same cycle, select EX (newer).
REQ-029 SHALL: capture rn == rm == same forwarded register identically on both operands.

Reset
REQ-030 SHALL: when rst=0 at posedge, set out_valid=0, out_a=out_b=out_imm=0, out_rd=0, out_reg_write=0, out_mem_read=0, stall_cnt=0.
REQ-031 SHALL: drive in_ready=0 while rst=0; reset mid-transfer discards the held bundle with no partial output.

Verification
REQ-032 SHALL: the bench shall cover wb_we=1, wb_addr=5, wb_data=0x1234, in_rn=5, rf_rdata1=0x9 -> out_a=0x1234 one cycle later.
REQ-033 SHALL: the bench shall cover ex_we=1, ex_addr=7, ex_data=0xAA, wb_we=1, wb_addr=7, wb_data=0xBB, in_rm=7 -> out_b=0xAA.
REQ-034 SHALL: the bench shall cover in_rn=31, ex_we=1, ex_addr=31, ex_data=0xFF -> out_a=0.
REQ-035 SHALL: the bench shall cover ex_is_load=1, ex_addr=3, in_rn=3 for 2 cycles -> in_ready=0, out_valid=0 (after drain), stall_cnt=2; ex_is_load cleared -> accept next cycle.
REQ-036 SHALL: the bench shall cover out_ready=0 for 3 cycles with in_valid=1 -> outputs held constant, in_ready=0, no instruction lost or duplicated.
REQ-037 SHALL: the bench shall cover rst=0 asserted while out_valid=1 -> next cycle out_valid=0, stall_cnt=0, all outputs 0.
